// File: rtl/sum_tree_pipe_if.sv
// Stream bundle for sum_tree_pipe: lane-parallel input beats in,
// one reduced sum and beat count per packet out, each side valid/ready.
interface sum_tree_pipe_if #(
    parameter int N         = 8,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic [N*WIDTH-1:0]   in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic [CNT_W-1:0]     out_beats;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/sum_tree_pipe.sv
// Registered binary adder tree over N lanes with per-packet
// accumulation and valid/ready flow control on both sides.
module sum_tree_pipe #(
    parameter int N         = 8,
    parameter int WIDTH     = 32,
    parameter int OUT_WIDTH = 32,
    parameter int CNT_W     = 16
) (
    input logic            clk,
    input logic            rst_n,
    sum_tree_pipe_if.slave bus
);
    localparam int L  = $clog2(N);
    localparam int TW = WIDTH + L;

    logic                 drain;
    logic                 lmv;
    logic                 llast;
    logic [TW-1:0]        tree_sum;
    logic [OUT_WIDTH-1:0] tsum;
    logic [OUT_WIDTH-1:0] acc_sum;
    logic [CNT_W-1:0]     cnt_inc;

    logic                 ov_q, ov_d;
    logic [OUT_WIDTH-1:0] od_q, od_d;
    logic [CNT_W-1:0]     ob_q, ob_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    assign drain = ov_q & bus.out_ready;

    for (genvar j = 1; j <= L; j++) begin : g_lvl
        localparam int W = WIDTH + j;
        localparam int M = N >> j;

        logic         v_q;
        logic         last_q;
        logic         ok;
        logic         ld;
        logic         src_v;
        logic         src_l;
        logic [W-1:0] s_q [M];
        logic [W-1:0] s_d [M];

        if (j == 1) begin : g_src
            assign src_v = bus.in_valid;
            assign src_l = bus.in_last;
            for (genvar i = 0; i < M; i++) begin : g_add
                assign s_d[i] =
                    {1'b0, bus.in_data[2*i*WIDTH +: WIDTH]} +
                    {1'b0, bus.in_data[(2*i+1)*WIDTH +: WIDTH]};
            end
        end else begin : g_src
            assign src_v = g_lvl[j-1].v_q;
            assign src_l = g_lvl[j-1].last_q;
            for (genvar i = 0; i < M; i++) begin : g_add
                assign s_d[i] =
                    {1'b0, g_lvl[j-1].s_q[2*i]} +
                    {1'b0, g_lvl[j-1].s_q[2*i+1]};
            end
        end

        // A closing beat may only leave the tree into a free output slot.
        if (j == L) begin : g_ok
            assign ok = !last_q | !ov_q | drain;
        end else begin : g_ok
            assign ok = g_lvl[j+1].ld;
        end

        assign ld = !v_q | ok;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v_q    <= 1'b0;
                last_q <= 1'b0;
                for (int i = 0; i < M; i++) s_q[i] <= '0;
            end else if (ld) begin
                v_q    <= src_v;
                last_q <= src_l;
                if (src_v) s_q <= s_d;
            end
        end
    end

    assign tree_sum = g_lvl[L].s_q[0];
    assign llast    = g_lvl[L].last_q;
    assign lmv      = g_lvl[L].v_q & g_lvl[L].ok;

    if (OUT_WIDTH >= TW) begin : g_ext
        assign tsum = OUT_WIDTH'(tree_sum);
    end else begin : g_trunc
        logic unused_hi;
        assign tsum      = tree_sum[OUT_WIDTH-1:0];
        assign unused_hi = ^tree_sum[TW-1:OUT_WIDTH];
    end

    assign acc_sum = acc_q + tsum;
    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        ov_d  = ov_q;
        od_d  = od_q;
        ob_d  = ob_q;
        acc_d = acc_q;
        cnt_d = cnt_q;
        if (drain) ov_d = 1'b0;
        if (lmv) begin
            if (llast) begin
                ov_d  = 1'b1;
                od_d  = acc_sum;
                ob_d  = cnt_inc;
                acc_d = '0;
                cnt_d = '0;
            end else begin
                acc_d = acc_sum;
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ov_q  <= 1'b0;
            od_q  <= '0;
            ob_q  <= '0;
            acc_q <= '0;
            cnt_q <= '0;
        end else begin
            ov_q  <= ov_d;
            od_q  <= od_d;
            ob_q  <= ob_d;
            acc_q <= acc_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = g_lvl[1].ld;
    assign bus.out_valid = ov_q;
    assign bus.out_data  = od_q;
    assign bus.out_beats = ob_q;
endmodule

// File: doc/sum_tree_pipe.md
# sum_tree_pipe

Pipelined, parametrised successor to the generated 8-input combinational sum blocks. Each beat carries N operand lanes, and those lanes are reduced through a registered binary adder tree. The block has valid/ready handshakes on both sides, a selectable output width (wrapping or widened) and accumulation of sums across a multi-beat packet. It sits between a lane-parallel producer and any consumer needing one reduced value per packet.

## Interface
Parameters:
- N, 8: operand lanes per beat; power of two, ≥2; L = log2(N) tree levels.
- WIDTH, 32: bits per lane.
- OUT_WIDTH, 32: result width; WIDTH ≤ OUT_WIDTH ≤ WIDTH+L+CNT_W.
- CNT_W, 16: width of beat counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input beat valid.
- in_ready  out  1  input beat accepted when in_valid & in_ready at rising edge.
- in_data  in  N*WIDTH  lane i = in_data[i*WIDTH +: WIDTH].
- in_last  in  1  beat closes packet; tie 1 for one result per beat.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts.
- out_data  out  OUT_WIDTH  packet sum mod 2^OUT_WIDTH.
- out_beats  out  CNT_W  beats in packet, saturating at 2^CNT_W-1.

## Operation
- Tree: level j (1..L) registers N/2^j partial sums, each WIDTH+j bits, full precision. Level 1 adds adjacent lane pairs (0+1, 2+3, ...). in_last travels with each beat through every level.
- Accumulator stage: acc (OUT_WIDTH bits) and cnt (CNT_W bits). Both reset to 0.
- Beat leaving level L, in_last=0: acc <= acc + sum (low OUT_WIDTH bits); cnt <= sat(cnt+1). No output. Always accepted.
- Beat leaving level L, in_last=1: output register <= acc + sum (low OUT_WIDTH bits) and out_beats <= sat(cnt+1). Then acc <= 0 and cnt <= 0.
- All arithmetic is modulo 2^OUT_WIDTH. Signed and unsigned operands give identical low bits. The tree result is zero-extended or truncated to OUT_WIDTH.
- Flow control per stage: stage s loads when it is empty or its content moves on this cycle.
  - The output register is draining when out_valid & out_ready.
  - A level-L beat with in_last=1 moves only if the output register is empty or draining. A level-L beat with in_last=0 always moves.
- in_ready = level-1 empty or level-1 advancing. It is combinational from downstream state and out_ready, and never from in_valid.
- Beats are never dropped, duplicated or reordered. out_data and out_beats hold stable while out_valid & !out_ready.
- Reset (asynchronous, any time, including mid-packet): all stage valids 0, out_valid 0, out_data 0, out_beats 0, acc 0, cnt 0. Any partial packet is discarded. in_ready is 1 in the first cycle after reset release.

## Timing
- Latency: a beat accepted at edge k with in_last=1 and no stalls produces out_valid=1 in the cycle after edge k+L. For N=8 that is edge k+3.
- Throughput: 1 beat per cycle while out_ready=1 or while packets are multi-beat.
- Under stall, capacity is L tree beats plus 1 output result. in_ready falls once all are full.
- When the output register drains and the level-L beat is last, the output register reloads in the same edge, so there is no bubble.
- The in_ready to in_valid path has no combinational loop. out_ready to in_ready is combinational through the stall chain.

## Test plan
- Single beat (N=8, WIDTH=32, OUT_WIDTH=32): lanes 1..8, in_last=1, out_ready=1.
  - Required: out_data=36 and out_beats=1.
  - out_valid asserts exactly in the cycle after edge k+3.
- Wrap and widen: all lanes 0xFFFFFFFF, in_last=1.
  - OUT_WIDTH=32 → out_data=0xFFFFFFF8.
  - OUT_WIDTH=35 → out_data=0x7FFFFFFF8.
- Packet: 3 beats of all-ones lanes (value 1 each), in_last only on the 3rd.
  - Required: exactly one output, out_data=24, out_beats=3.
  - A following single-beat packet of lanes 0..7 gives out_data=28 and out_beats=1.
- Backpressure: in_valid=1 continuously, in_last=1, lanes = beat index in every lane; out_ready=0 for 10 cycles, then 1.
  - in_ready falls after 4 accepted beats.
  - Outputs then appear as 0, 8, 16, 24, ... in order, one per cycle, with none lost.
- Random out_ready and in_valid at 50% with 1000 packets of random length 1–5, checked against a model.
  - Required: all sums and counts match.
  - Outputs hold stable while stalled.
- Reset mid-packet: accumulate 2 non-last beats, pulse rst_n low asynchronously between edges.
  - out_valid drops immediately.
  - The next packet (lanes 1..8, last) gives out_data=36 and out_beats=1.
- Counter saturation: CNT_W=2, 5-beat packet of ones (N=8).
  - Required: out_beats=3 and out_data=40.
